mc_control_32: RTL
==================

# mc_control_32

Multicycle main controller for the 32-bit MIPS datapath. It decodes the 6-bit opcode and sequences each instruction through fetch, decode, execute, memory and writeback steps, one step per clock. It drives the shared ALU, register-file, PC and memory-port selects and strobes, and stalls on a single memory ready handshake. It replaces the single-cycle main decoder when the datapath is built with one shared memory and one ALU.

## Interface
- No parameters.
- clk  in  1  system clock, rising edge.
- rst  in  1  reset, asynchronous, active-high.
- instruction_special  in  6  opcode field `IR[31:26]`, valid from DECODE onward.
- mem_ready  in  1  memory has completed the current read or write this cycle.
- ALUOp  out  2  `00` add, `01` subtract, `10` use funct field.
- ALUSrcA  out  1  `0` PC, `1` register A.
- ALUSrcB  out  2  `00` register B, `01` constant 4, `10` sign-extended immediate, `11` sign-extended immediate shifted left by 2.
- IorD  out  1  memory address select: `0` PC, `1` ALUOut.
- MemRead, MemWrite  out  1 each  memory strobes.
- IRWrite  out  1  instruction-register load enable.
- RegDst  out  1  destination select: `1` rd, `0` rt.
- MemtoReg  out  1  writeback select: `1` MDR, `0` ALUOut.
- RegWrite  out  1  register-file write enable.
- PCSrc  out  2  `00` ALU result, `01` ALUOut, `10` jump target.
- PCWrite  out  1  unconditional PC write.
- Branch  out  1  PC write qualified by ALU zero; gated externally.
- illegal_op  out  1  one-cycle pulse in DECODE when the opcode is unsupported.
- state  out  4  current state encoding, for debug.

## Operation
- The block is a Moore FSM with a 4-bit state register.
  - Outputs decode from state.
  - Exceptions: IRWrite/PCWrite in FETCH, and the progression out of MEMRD/MEMWR, are qualified by mem_ready.
- Every output not listed for a state is 0.
- States, with their encodings, asserted outputs and next state:
  - FETCH (0): MemRead, ALUSrcB=`01`, ALUOp=`00`, PCSrc=`00`. When mem_ready=1, also IRWrite and PCWrite, and go to DECODE. Otherwise hold with IRWrite=PCWrite=0.
  - DECODE (1): ALUSrcB=`11`, ALUOp=`00`. Next state by opcode:
    - `100011` or `101011` → MEMADR
    - `000000` → EXEC
    - `000100` → BEQ
    - `000010` → JUMP
    - `001000` → ADDIEX (only when the ADDI feature is compiled in)
    - any other opcode → FETCH, with illegal_op=1
  - MEMADR (2): ALUSrcA=1, ALUSrcB=`10`, ALUOp=`00`. Next is MEMRD for `100011`, MEMWR for `101011`. The opcode is re-sampled here; IR is stable.
  - MEMRD (3): MemRead, IorD=1. Go to MEMWB when mem_ready=1, else hold.
  - MEMWB (4): RegWrite, MemtoReg=1, RegDst=0. Next is FETCH.
  - MEMWR (5): MemWrite, IorD=1. Go to FETCH when mem_ready=1, else hold with MemWrite kept at 1.
  - EXEC (6): ALUSrcA=1, ALUSrcB=`00`, ALUOp=`10`. Next is ALUWB.
  - ALUWB (7): RegWrite, RegDst=1, MemtoReg=0. Next is FETCH.
  - BEQ (8): ALUSrcA=1, ALUSrcB=`00`, ALUOp=`01`, PCSrc=`01`, Branch. Next is FETCH.
  - ADDIEX (9): ALUSrcA=1, ALUSrcB=`10`, ALUOp=`00`. Next is ADDIWB.
  - ADDIWB (10): RegWrite, RegDst=0, MemtoReg=0. Next is FETCH.
  - JUMP (11): PCSrc=`10`, PCWrite. Next is FETCH.
  - Encodings 12–15 are unused and go to FETCH on the next edge. No output strobe is asserted in them.
- Reset:
  - rst=1 forces state=FETCH immediately.
  - While rst=1, IRWrite, PCWrite, MemWrite, RegWrite, Branch and illegal_op are forced to 0.
  - rst asserted mid-instruction abandons it. No partial register or memory write completes after rst rises.

## Timing
- Transitions occur on the rising clk edge.
- Outputs are valid combinationally within the same cycle as the state.
- With mem_ready held at 1, cycles per instruction are:
  - R-type: 4
  - lw: 5
  - sw: 4
  - beq: 3
  - j: 3
  - addi: 4
- Each cycle with mem_ready=0 in FETCH, MEMRD or MEMWR adds exactly one cycle. No other state waits.
- mem_ready is ignored in every state other than FETCH, MEMRD and MEMWR.
- First FETCH after rst deasserts: a fetch completes on the first edge where mem_ready=1.

## Configuration
- MC_CONTROL_ADDI_EN defined: opcode `001000` follows DECODE→ADDIEX→ADDIWB→FETCH.
- MC_CONTROL_ADDI_EN undefined:
  - ADDIEX and ADDIWB do not exist and their encodings behave as unused.
  - Opcode `001000` is illegal: illegal_op pulses and the FSM returns to FETCH.

## Test plan
- rst pulse mid-EXEC → state=0 within the same cycle. No RegWrite is seen. After release, the first cycle shows MemRead=1 and ALUSrcB=`01`.
- R-type (opcode `000000`), mem_ready=1 → states 0,1,6,7,0. RegWrite=1 and RegDst=1 only in state 7. Total 4 cycles.
- lw (`100011`) with mem_ready=0 for 2 cycles in MEMRD → states 0,1,2,3,3,3,4. IorD=1 throughout MEMRD. MemtoReg=1 in MEMWB. Total 7 cycles.
- sw (`101011`), then beq (`000100`) → sw gives MemWrite=1 only in state 5 with IorD=1. beq gives Branch=1, ALUOp=`01` and PCSrc=`01` in state 8, and completes in 3 cycles.
- j (`000010`) → PCWrite=1 with PCSrc=`10` in state 11. Opcode `111111` → illegal_op=1 for exactly one cycle in DECODE, then FETCH.
- addi (`001000`) → with MC_CONTROL_ADDI_EN: states 1,9,10, with ALUSrcB=`10` in state 9 and RegWrite/RegDst=0 in state 10. Without MC_CONTROL_ADDI_EN: illegal_op pulse, then FETCH.

Source files
------------

// File: rtl/mc_control_32_if.sv
// Control bundle between the multicycle MIPS controller and its datapath.
// The controller sits on the slave modport; the datapath or bench drives the master side.
interface mc_control_32_if;
   logic [5:0] instruction_special;
   logic       mem_ready;
   logic [1:0] ALUOp;
   logic       ALUSrcA;
   logic [1:0] ALUSrcB;
   logic       IorD;
   logic       MemRead;
   logic       MemWrite;
   logic       IRWrite;
   logic       RegDst;
   logic       MemtoReg;
   logic       RegWrite;
   logic [1:0] PCSrc;
   logic       PCWrite;
   logic       Branch;
   logic       illegal_op;
   logic [3:0] state;

   modport master (
      output instruction_special, mem_ready,
      input  ALUOp, ALUSrcA, ALUSrcB, IorD, MemRead, MemWrite, IRWrite, RegDst,
             MemtoReg, RegWrite, PCSrc, PCWrite, Branch, illegal_op, state
   );

   modport slave (
      input  instruction_special, mem_ready,
      output ALUOp, ALUSrcA, ALUSrcB, IorD, MemRead, MemWrite, IRWrite, RegDst,
             MemtoReg, RegWrite, PCSrc, PCWrite, Branch, illegal_op, state
   );
endinterface

// File: rtl/mc_control_32.sv
// Multicycle MIPS main controller: Moore FSM sequencing fetch/decode/execute/mem/writeback.
// Define MC_CONTROL_ADDI_EN to add the addi path (ADDIEX/ADDIWB); otherwise addi is illegal.
module mc_control_32 (
   input logic          clk,
   input logic          rst,
   mc_control_32_if.slave bus
);

   typedef enum logic [3:0] {
      StFetch  = 4'd0,
      StDecode = 4'd1,
      StMemAdr = 4'd2,
      StMemRd  = 4'd3,
      StMemWb  = 4'd4,
      StMemWr  = 4'd5,
      StExec   = 4'd6,
      StAluWb  = 4'd7,
      StBeq    = 4'd8,
      StAddiEx = 4'd9,
      StAddiWb = 4'd10,
      StJump   = 4'd11
   } state_t;

   localparam logic [5:0] OpRtype = 6'b000000;
   localparam logic [5:0] OpLw    = 6'b100011;
   localparam logic [5:0] OpSw    = 6'b101011;
   localparam logic [5:0] OpBeq   = 6'b000100;
   localparam logic [5:0] OpJ     = 6'b000010;
   localparam logic [5:0] OpAddi  = 6'b001000;

   state_t state_q;
   logic   op_legal;

   always_comb begin
      unique case (bus.instruction_special)
         OpRtype, OpLw, OpSw, OpBeq, OpJ: op_legal = 1'b1;
`ifdef MC_CONTROL_ADDI_EN
         OpAddi:                          op_legal = 1'b1;
`endif
         default:                         op_legal = 1'b0;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= StFetch;
      end else begin
         case (state_q)
            StFetch:  if (bus.mem_ready) state_q <= StDecode;
            StDecode: begin
               case (bus.instruction_special)
                  OpLw, OpSw: state_q <= StMemAdr;
                  OpRtype:    state_q <= StExec;
                  OpBeq:      state_q <= StBeq;
                  OpJ:        state_q <= StJump;
`ifdef MC_CONTROL_ADDI_EN
                  OpAddi:     state_q <= StAddiEx;
`endif
                  default:    state_q <= StFetch;
               endcase
            end
            StMemAdr: state_q <= (bus.instruction_special == OpSw) ? StMemWr : StMemRd;
            StMemRd:  if (bus.mem_ready) state_q <= StMemWb;
            StMemWr:  if (bus.mem_ready) state_q <= StFetch;
            StExec:   state_q <= StAluWb;
`ifdef MC_CONTROL_ADDI_EN
            StAddiEx: state_q <= StAddiWb;
`endif
            // Writeback, branch, jump and unused encodings all return to fetch.
            default:  state_q <= StFetch;
         endcase
      end
   end

   logic [1:0] alu_op, alu_src_b, pc_src;
   logic       alu_src_a, iord, mem_read, mem_write, ir_write, reg_dst, memto_reg;
   logic       reg_write, pc_write, branch, illegal;

   always_comb begin
      alu_op    = 2'b00;
      alu_src_a = 1'b0;
      alu_src_b = 2'b00;
      iord      = 1'b0;
      mem_read  = 1'b0;
      mem_write = 1'b0;
      ir_write  = 1'b0;
      reg_dst   = 1'b0;
      memto_reg = 1'b0;
      reg_write = 1'b0;
      pc_src    = 2'b00;
      pc_write  = 1'b0;
      branch    = 1'b0;
      illegal   = 1'b0;
      case (state_q)
         StFetch: begin
            mem_read  = 1'b1;
            alu_src_b = 2'b01;
            ir_write  = bus.mem_ready;
            pc_write  = bus.mem_ready;
         end
         StDecode: begin
            alu_src_b = 2'b11;
            illegal   = ~op_legal;
         end
         StMemAdr: begin
            alu_src_a = 1'b1;
            alu_src_b = 2'b10;
         end
         StMemRd: begin
            mem_read = 1'b1;
            iord     = 1'b1;
         end
         StMemWb: begin
            reg_write = 1'b1;
            memto_reg = 1'b1;
         end
         StMemWr: begin
            mem_write = 1'b1;
            iord      = 1'b1;
         end
         StExec: begin
            alu_src_a = 1'b1;
            alu_op    = 2'b10;
         end
         StAluWb: begin
            reg_write = 1'b1;
            reg_dst   = 1'b1;
         end
         StBeq: begin
            alu_src_a = 1'b1;
            alu_op    = 2'b01;
            pc_src    = 2'b01;
            branch    = 1'b1;
         end
`ifdef MC_CONTROL_ADDI_EN
         StAddiEx: begin
            alu_src_a = 1'b1;
            alu_src_b = 2'b10;
         end
         StAddiWb: reg_write = 1'b1;
`endif
         StJump: begin
            pc_src   = 2'b10;
            pc_write = 1'b1;
         end
         default: ;
      endcase
   end

   // Strobes are squashed while rst is high so no partial write escapes an abandoned instruction.
   assign bus.ALUOp      = alu_op;
   assign bus.ALUSrcA    = alu_src_a;
   assign bus.ALUSrcB    = alu_src_b;
   assign bus.IorD       = iord;
   assign bus.MemRead    = mem_read;
   assign bus.MemWrite   = mem_write & ~rst;
   assign bus.IRWrite    = ir_write & ~rst;
   assign bus.RegDst     = reg_dst;
   assign bus.MemtoReg   = memto_reg;
   assign bus.RegWrite   = reg_write & ~rst;
   assign bus.PCSrc      = pc_src;
   assign bus.PCWrite    = pc_write & ~rst;
   assign bus.Branch     = branch & ~rst;
   assign bus.illegal_op = illegal & ~rst;
   assign bus.state      = state_q;

endmodule
